sled_scan: RTL and testbench
============================

# sled_scan

Multiplexed N-digit seven-segment display driver with hex decoding, tear-free value update, leading-zero blanking, per-digit decimal points and inter-digit dead time.
- Sits between the application logic and the board's SEG/DIG pins.
- Unlike a single-pattern static driver, it time-multiplexes one segment bus across NUM_DIGITS common-anode digits.
- Output polarity is parametrised.

## Interface
- NUM_DIGITS, 4, number of digits (1–8); digit 0 is least significant (rightmost).
- SCAN_DIV, 12500, clock cycles per digit slot (default 50 MHz / 4 digits gives 1 kHz frame rate).
- BLANK_CYCLES, 500, dead-time cycles at the start of each slot with all digits off. Legal range is 0 ≤ BLANK_CYCLES < SCAN_DIV.
- SEG_ACTIVE_LOW, 1, when 1 a lit segment drives 0.
- DIG_ACTIVE_LOW, 1, when 1 an enabled digit drives 0.

Ports:
- FPGA_CLK  in  1  system clock; all logic is on its rising edge.
- RST  in  1  synchronous, active-high reset.
- VALUE  in  4*NUM_DIGITS  hex value; nibble i belongs to digit i.
- DP  in  NUM_DIGITS  decimal-point enables; bit i belongs to digit i.
- LOAD  in  1  one-cycle strobe that captures VALUE and DP.
- LZB_EN  in  1  leading-zero blanking enable; sampled live.
- SEG  out  8  registered segment bus: {dp, g, f, e, d, c, b, a}.
- DIG  out  NUM_DIGITS  registered digit enables; one-hot when driving.
- FRAME_DONE  out  1  one-cycle pulse on the last cycle of each frame.

## Operation
**State machine:** two states per slot, BLANK then DRIVE.
- BLANK lasts BLANK_CYCLES cycles:
  - DIG all off, SEG off.
  - Skipped entirely when BLANK_CYCLES = 0.
- DRIVE lasts SCAN_DIV − BLANK_CYCLES cycles:
  - DIG enables only the current digit index `idx`.
  - SEG shows decode(nibble[idx]) with the dp bit from DP[idx].
- At the end of each slot, `idx` increments. It wraps from NUM_DIGITS−1 to 0; the wrap marks a frame boundary.

**Value update:**
- LOAD writes VALUE/DP into a pending register and sets `pend`.
- A frame boundary with `pend` set copies pending into the display register and clears `pend`.
- Several LOADs within one frame: last one wins.
- LOAD in the same cycle as a boundary goes to pending and is shown from the following frame.
- The displayed data never changes mid-frame.

**Decode:** active-low codes (a..g on bits 0..6):
- 0→C0, 1→F9, 2→A4, 3→B0, 4→99, 5→92, 6→82, 7→F8
- 8→80, 9→90, A→88, B→83, C→C6, D→A1, E→86, F→8E
- dp lit clears bit 7.
- When SEG_ACTIVE_LOW = 0, the whole byte is inverted.

**Leading-zero blanking:**
- With LZB_EN = 1, digit i > 0 is blanked (segments a–g off) when nibble i and every higher nibble are 0.
- Digit 0 is never blanked.
- A blanked digit still lights dp if DP[i] = 1.

**Reset:**
- SEG = all segments off (8'hFF when active-low).
- DIG = all off.
- FRAME_DONE = 0.
- idx = 0, state = BLANK (DRIVE if BLANK_CYCLES = 0), slot counter = 0.
- Display, pending and `pend` cleared, so the first frame after reset shows "0", or all zeros with LZB off.
- RST mid-frame aborts the slot immediately; the outputs are off on the next cycle.

## Timing
- SEG/DIG are registered: they change on the clock edge where the slot counter crosses a state boundary, and SEG and DIG always change in the same cycle.
- Slot period is exactly SCAN_DIV cycles; frame period is exactly NUM_DIGITS × SCAN_DIV cycles.
- FRAME_DONE is high during the final cycle of digit NUM_DIGITS−1's DRIVE phase.
- LOAD-to-display latency: from 1 cycle up to one frame plus 1 cycle.
- The slot counter is ceil(log2(SCAN_DIV)) bits wide and wraps to 0 each slot; `idx` is max(1, ceil(log2(NUM_DIGITS))) bits wide.

## Structure
- Package `sled_pkg` holds:
  - the 16-entry active-low segment code constants,
  - SEG_OFF = 8'hFF,
  - the BLANK/DRIVE state encoding.
- Sub-module `sled_hex2seg`: combinational nibble+dp → 8-bit active-low code. The polarity inversion stays in the top level.
- Top level holds the prescaler, FSM, idx, pending/display registers, LZB mask and output registers.

## Test plan
Simulation parameters: NUM_DIGITS = 4, SCAN_DIV = 8, BLANK_CYCLES = 2, active-low outputs.
1. **Reset:** RST high 3 cycles.
   - During reset and the 2 BLANK cycles that follow: SEG = 8'hFF, DIG = 4'hF.
   - Then DIG = 4'b1110, SEG = 8'hC0.
   - FRAME_DONE pulses every 32 cycles.
2. **Basic decode:** LOAD VALUE = 16'h12AF, LZB_EN = 0. Next frame shows:
   - DIG 1110 → SEG 8E
   - DIG 1101 → SEG 88
   - DIG 1011 → SEG A4
   - DIG 0111 → SEG F9
3. **Leading-zero blanking:** LZB_EN = 1.
   - 16'h0005: digits 3–1 show SEG = FF with DIG active; digit 0 shows 92.
   - 16'h0400: digit 1 shows C0 (not blanked); digit 3 is blanked.
4. **Tear-free update:** LOAD 16'h1111 in digit 2 DRIVE, then LOAD 16'h2222 two cycles later.
   - The remainder of the current frame keeps the old value.
   - The next frame shows all digits A4, never F9.
5. **Decimal point:** DP = 4'b0100 with LZB_EN = 1 and VALUE = 0.
   - Digit 2 shows SEG = 7F.
   - Digit 0 shows C0.
6. **Reset mid-operation:** RST pulsed during digit 1 DRIVE, after loading 16'hBEEF.
   - The next cycle gives SEG = FF, DIG = F.
   - The display restarts at digit 0 showing C0; the old value is lost.

Source files
------------

// File: rtl/sled_pkg.sv
// Shared constants and types for the multiplexed seven-segment driver.
package sled_pkg;

    // Every segment dark on an active-low bus.
    localparam logic [7:0] SEG_OFF = 8'hFF;

    // Active-low codes {dp, g, f, e, d, c, b, a}; entry n is the glyph for hex digit n.
    localparam logic [15:0][7:0] SEG_CODES = {
        8'h8E, 8'h86, 8'hA1, 8'hC6,   // F E D C
        8'h83, 8'h88, 8'h90, 8'h80,   // B A 9 8
        8'hF8, 8'h82, 8'h92, 8'h99,   // 7 6 5 4
        8'hB0, 8'hA4, 8'hF9, 8'hC0    // 3 2 1 0
    };

    // Each digit slot is a dead-time phase followed by a drive phase.
    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } sled_state_e;

endpackage

// File: rtl/sled_hex2seg.sv
// Nibble plus decimal point to active-low segment code; polarity is handled by the caller.
module sled_hex2seg
    import sled_pkg::*;
(
    input  logic [3:0] nib_i,
    input  logic       dp_i,
    output logic [7:0] code_c_o
);

    // Glyph lookup with the dp bit pulled low when the point is lit.
    assign code_c_o = {~dp_i, SEG_CODES[nib_i][6:0]};

endmodule

// File: rtl/sled_scan.sv
// Time-multiplexed N-digit seven-segment driver with tear-free update,
// leading-zero blanking, per-digit decimal points and inter-digit dead time.
module sled_scan
    import sled_pkg::*;
#(
    parameter int unsigned NUM_DIGITS     = 4,
    parameter int unsigned SCAN_DIV       = 12500,
    parameter int unsigned BLANK_CYCLES   = 500,
    parameter int unsigned SEG_ACTIVE_LOW = 1,
    parameter int unsigned DIG_ACTIVE_LOW = 1
) (
    input  logic                      FPGA_CLK,
    input  logic                      RST,
    input  logic [4*NUM_DIGITS-1:0]   VALUE,
    input  logic [NUM_DIGITS-1:0]     DP,
    input  logic                      LOAD,
    input  logic                      LZB_EN,
    output logic [7:0]                SEG,
    output logic [NUM_DIGITS-1:0]     DIG,
    output logic                      FRAME_DONE
);

    localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned VAL_W = 4 * NUM_DIGITS;

    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES == 0) ? 0 : BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    // Without dead time every slot starts directly in the drive phase.
    localparam sled_state_e ST_SLOT_START = (BLANK_CYCLES == 0) ? ST_DRIVE : ST_BLANK;

    localparam logic [7:0]            SEG_IDLE = (SEG_ACTIVE_LOW != 0) ? SEG_OFF : ~SEG_OFF;
    localparam logic [NUM_DIGITS-1:0] DIG_IDLE = (DIG_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}}
                                                                      : {NUM_DIGITS{1'b0}};

    sled_state_e            state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0]       idx_q, idx_d;

    logic                   pend_q, pend_d;
    logic [VAL_W-1:0]       pend_val_q, pend_val_d;
    logic [NUM_DIGITS-1:0]  pend_dp_q, pend_dp_d;
    logic [VAL_W-1:0]       disp_val_q, disp_val_d;
    logic [NUM_DIGITS-1:0]  disp_dp_q, disp_dp_d;

    logic [7:0]             seg_q, seg_d;
    logic [NUM_DIGITS-1:0]  dig_q, dig_d;
    logic                   fd_q, fd_d;

    logic                   slot_end;
    logic                   frame_end;

    logic [NUM_DIGITS-1:0]  lzb_mask;
    logic                   nz_above;
    logic [3:0]             cur_nib;
    logic                   cur_dp;
    logic                   cur_blank;
    logic [NUM_DIGITS-1:0]  dig_hot;
    logic [7:0]             hex_code;
    logic [7:0]             seg_raw;

    // Slot sequencer: prescaler, BLANK/DRIVE phase and digit index.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CNT_W'(1);
        idx_d     = idx_q;
        slot_end  = (cnt_q == CNT_LAST);
        frame_end = slot_end && (idx_q == IDX_LAST);

        if (slot_end) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end

        case (state_q)
            ST_BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    state_d = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                if (slot_end) begin
                    state_d = ST_SLOT_START;
                end
            end
            default: state_d = ST_SLOT_START;
        endcase
    end

    // Pending/display registers: LOAD always lands in pending, frame boundary promotes it.
    always_comb begin
        pend_d     = pend_q;
        pend_val_d = pend_val_q;
        pend_dp_d  = pend_dp_q;
        disp_val_d = disp_val_q;
        disp_dp_d  = disp_dp_q;

        if (frame_end && pend_q) begin
            disp_val_d = pend_val_q;
            disp_dp_d  = pend_dp_q;
            pend_d     = 1'b0;
        end
        if (LOAD) begin
            pend_val_d = VALUE;
            pend_dp_d  = DP;
            pend_d     = 1'b1;
        end
    end

    // Leading-zero mask: digit i is blankable when it and every higher nibble are zero.
    always_comb begin
        lzb_mask = '0;
        nz_above = 1'b0;
        for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
            nz_above    = nz_above | (disp_val_d[4*i +: 4] != 4'h0);
            lzb_mask[i] = ~nz_above & (i != 0);
        end
    end

    // Select the nibble, dp and blank flag of the digit about to be driven.
    always_comb begin
        cur_nib   = 4'h0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        dig_hot   = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            dig_hot[i] = (idx_d == IDX_W'(i));
            if (idx_d == IDX_W'(i)) begin
                cur_nib   = disp_val_d[4*i +: 4];
                cur_dp    = disp_dp_d[i];
                cur_blank = LZB_EN & lzb_mask[i];
            end
        end
    end

    sled_hex2seg u_hex2seg (
        .nib_i    (cur_nib),
        .dp_i     (cur_dp),
        .code_c_o (hex_code)
    );

    // Output next-state: built from the upcoming phase so SEG/DIG switch on the boundary edge.
    always_comb begin
        seg_raw = cur_blank ? {hex_code[7], 7'h7F} : hex_code;
        seg_d   = SEG_IDLE;
        dig_d   = DIG_IDLE;
        fd_d    = (state_d == ST_DRIVE) && (cnt_d == CNT_LAST) && (idx_d == IDX_LAST);

        if (state_d == ST_DRIVE) begin
            seg_d = (SEG_ACTIVE_LOW != 0) ? seg_raw : ~seg_raw;
            dig_d = (DIG_ACTIVE_LOW != 0) ? ~dig_hot : dig_hot;
        end
    end

    // Sequencer state register.
    always_ff @(posedge FPGA_CLK) begin
        if (RST) begin
            state_q <= ST_SLOT_START;
            cnt_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
        end
    end

    // Pending and display data registers.
    always_ff @(posedge FPGA_CLK) begin
        if (RST) begin
            pend_q     <= 1'b0;
            pend_val_q <= '0;
            pend_dp_q  <= '0;
            disp_val_q <= '0;
            disp_dp_q  <= '0;
        end else begin
            pend_q     <= pend_d;
            pend_val_q <= pend_val_d;
            pend_dp_q  <= pend_dp_d;
            disp_val_q <= disp_val_d;
            disp_dp_q  <= disp_dp_d;
        end
    end

    // Registered pin drivers.
    always_ff @(posedge FPGA_CLK) begin
        if (RST) begin
            seg_q <= SEG_IDLE;
            dig_q <= DIG_IDLE;
            fd_q  <= 1'b0;
        end else begin
            seg_q <= seg_d;
            dig_q <= dig_d;
            fd_q  <= fd_d;
        end
    end

    assign SEG        = seg_q;
    assign DIG        = dig_q;
    assign FRAME_DONE = fd_q;

endmodule

// File: tb/tb_sled_scan.sv
// Directed bench for sled_scan with a cycle-level reference model of the display timeline.
module tb_sled_scan;

    localparam int ND = 4;
    localparam int SD = 8;
    localparam int BC = 2;
    localparam int FRAME = ND * SD;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] value;
    logic [3:0]  dp;
    logic        load;
    logic        lzb;
    logic [7:0]  seg;
    logic [3:0]  dig;
    logic        fd;

    int errors = 0;
    int checks = 0;

    // Model state: cycles since reset, data on display this frame, most recent load.
    int          mdl_t = 0;
    logic        armed = 1'b0;
    logic [15:0] shown = '0;
    logic [3:0]  shown_dp = '0;
    logic [15:0] latest = '0;
    logic [3:0]  latest_dp = '0;

    always #5 clk = ~clk;

    sled_scan #(
        .NUM_DIGITS     (ND),
        .SCAN_DIV       (SD),
        .BLANK_CYCLES   (BC),
        .SEG_ACTIVE_LOW (1),
        .DIG_ACTIVE_LOW (1)
    ) dut (
        .FPGA_CLK   (clk),
        .RST        (rst),
        .VALUE      (value),
        .DP         (dp),
        .LOAD       (load),
        .LZB_EN     (lzb),
        .SEG        (seg),
        .DIG        (dig),
        .FRAME_DONE (fd)
    );

    function automatic logic [7:0] seg_of(input logic [3:0] n);
        case (n)
            4'h0: return 8'hC0;  4'h1: return 8'hF9;  4'h2: return 8'hA4;  4'h3: return 8'hB0;
            4'h4: return 8'h99;  4'h5: return 8'h92;  4'h6: return 8'h82;  4'h7: return 8'hF8;
            4'h8: return 8'h80;  4'h9: return 8'h90;  4'hA: return 8'h88;  4'hB: return 8'h83;
            4'hC: return 8'hC6;  4'hD: return 8'hA1;  4'hE: return 8'h86;  default: return 8'h8E;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0d: got %0h expected %0h", name, mdl_t, act, exp);
        end
    endtask

    // One clock: sample inputs at the edge, advance the model, compare at the falling edge.
    task automatic step();
        logic        s_rst, s_load, s_lzb;
        logic [15:0] s_val, sh;
        logic [3:0]  s_dp, ed;
        logic [7:0]  es;
        logic        efd;
        int          p, k;
        @(posedge clk);
        s_rst = rst; s_load = load; s_val = value; s_dp = dp; s_lzb = lzb;
        @(negedge clk);
        if (s_rst) begin
            armed = 1'b1; mdl_t = 0;
            shown = '0; shown_dp = '0; latest = '0; latest_dp = '0;
        end else if (armed) begin
            mdl_t++;
            if (mdl_t % FRAME == 0) begin
                shown    = latest;
                shown_dp = latest_dp;
            end
            if (s_load) begin
                latest    = s_val;
                latest_dp = s_dp;
            end
        end
        if (armed) begin
            p  = mdl_t % SD;
            k  = (mdl_t / SD) % ND;
            es = 8'hFF;
            ed = 4'hF;
            if (p >= BC) begin
                ed = 4'hF & ~(4'b0001 << k);
                sh = shown >> (4 * k);
                if (s_lzb && k > 0 && sh == 16'h0) es = 8'hFF;
                else                               es = seg_of(sh[3:0]);
                if (shown_dp[k]) es[7] = 1'b0;
            end
            efd = (mdl_t % FRAME == FRAME - 1) && !s_rst;
            chk("cyc_seg", 32'(seg), 32'(es));
            chk("cyc_dig", 32'(dig), 32'(ed));
            chk("cyc_frame_done", 32'(fd), 32'(efd));
        end
    endtask

    task automatic goto_t(input int tt);
        int n = 0;
        while (mdl_t != tt && n < 2000) begin
            step();
            n++;
        end
        checks++;
        if (mdl_t != tt) begin
            errors++;
            $display("FAIL goto_t: reached t=%0d required %0d", mdl_t, tt);
        end
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d);
        value = v; dp = d; load = 1'b1;
        step();
        load = 1'b0;
    endtask

    task automatic lit(input string name, input logic [7:0] es, input logic [3:0] ed);
        chk({name, "_seg"}, 32'(seg), 32'(es));
        chk({name, "_dig"}, 32'(dig), 32'(ed));
    endtask

    initial begin
        rst = 1'b1; value = '0; dp = '0; load = 1'b0; lzb = 1'b0;
        repeat (3) step();
        lit("rst_hold", 8'hFF, 4'hF);
        chk("rst_fd", 32'(fd), 32'd0);
        rst = 1'b0;

        // Reset recovery: two dark cycles then digit 0 shows "0".
        goto_t(1);  lit("rst_blank", 8'hFF, 4'hF);
        goto_t(2);  lit("rst_first", 8'hC0, 4'b1110);

        // Basic decode, shown from the next frame.
        goto_t(5);  do_load(16'h12AF, 4'b0000);
        goto_t(30); chk("fd_low", 32'(fd), 32'd0);
        goto_t(31); chk("fd_pulse", 32'(fd), 32'd1);
        goto_t(34); lit("dec_d0", 8'h8E, 4'b1110);
        goto_t(42); lit("dec_d1", 8'h88, 4'b1101);
        goto_t(50); lit("dec_d2", 8'hA4, 4'b1011);
        goto_t(58); lit("dec_d3", 8'hF9, 4'b0111);

        // Leading-zero blanking.
        goto_t(60); lzb = 1'b1; do_load(16'h0005, 4'b0000);
        goto_t(63); chk("fd_pulse2", 32'(fd), 32'd1);
        goto_t(66); lit("lzb5_d0", 8'h92, 4'b1110);
        goto_t(74); lit("lzb5_d1", 8'hFF, 4'b1101);
        goto_t(82); lit("lzb5_d2", 8'hFF, 4'b1011);
        goto_t(90); lit("lzb5_d3", 8'hFF, 4'b0111);
        goto_t(92); do_load(16'h0400, 4'b0000);
        goto_t(98);  lit("lzb4_d0", 8'hC0, 4'b1110);
        goto_t(106); lit("lzb4_d1", 8'hC0, 4'b1101);
        goto_t(114); lit("lzb4_d2", 8'h99, 4'b1011);
        goto_t(122); lit("lzb4_d3", 8'hFF, 4'b0111);

        // Tear-free update: two loads during digit 2, last one wins next frame.
        goto_t(146); do_load(16'h1111, 4'b0000);
        goto_t(148); do_load(16'h2222, 4'b0000);
        goto_t(150); lit("tear_d2_old", 8'h99, 4'b1011);
        goto_t(154); lit("tear_d3_old", 8'hFF, 4'b0111);
        goto_t(162); lit("tear_d0", 8'hA4, 4'b1110);
        goto_t(170); lit("tear_d1", 8'hA4, 4'b1101);
        goto_t(178); lit("tear_d2", 8'hA4, 4'b1011);
        goto_t(186); lit("tear_d3", 8'hA4, 4'b0111);

        // Decimal point on a blanked digit.
        goto_t(188); do_load(16'h0000, 4'b0100);
        goto_t(194); lit("dp_d0", 8'hC0, 4'b1110);
        goto_t(202); lit("dp_d1", 8'hFF, 4'b1101);
        goto_t(210); lit("dp_d2", 8'h7F, 4'b1011);
        goto_t(218); lit("dp_d3", 8'hFF, 4'b0111);

        // Reset in the middle of digit 1 drive discards BEEF.
        goto_t(220); do_load(16'hBEEF, 4'b0000);
        goto_t(234); lit("beef_d1", 8'h86, 4'b1101);
        rst = 1'b1;
        step();
        lit("mid_rst", 8'hFF, 4'hF);
        rst = 1'b0;
        goto_t(1);  lit("post_rst_blank", 8'hFF, 4'hF);
        goto_t(2);  lit("post_rst_d0", 8'hC0, 4'b1110);
        goto_t(10); lit("post_rst_d1", 8'hFF, 4'b1101);
        goto_t(31); chk("post_rst_fd", 32'(fd), 32'd1);
        goto_t(34); lit("post_rst_f1", 8'hC0, 4'b1110);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
